// File: rtl/riscv_instr_encoder.sv
// Boot-time program loader: encodes symbolic RV32I requests and streams them into
// instruction memory, holding the core in reset until a clean program is loaded.
//   state | meaning
//   IDLE  | after reset, waiting for start
//   LOAD  | accepting and writing instructions
//   DONE  | program complete, core released
//   ERR   | session aborted, err_code valid
module riscv_instr_encoder #(
  parameter int ADDR_W     = 8,
  parameter int START_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_kind,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [31:0]       in_imm,
  input  logic              in_last,
  output logic              mem_we,
  output logic [ADDR_W+1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [ADDR_W:0]   count,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_code,
  output logic              cpu_hold
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE, S_ERR} state_t;

  localparam logic [ADDR_W-1:0] START_W = ADDR_W'(START_ADDR);
  localparam logic [ADDR_W-1:0] LAST_W  = '1;
  localparam logic [ADDR_W-1:0] ONE_W   = ADDR_W'(1);
  localparam logic [ADDR_W:0]   ONE_C   = (ADDR_W+1)'(1);

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_IMM  = 7'b0010011;
  localparam logic [6:0] OP_LD   = 7'b0000011;
  localparam logic [6:0] OP_ST   = 7'b0100011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_LUI  = 7'b0110111;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   word_q, word_d;
  logic [ADDR_W:0]     count_q, count_d;
  logic [1:0]          code_q, code_d;
  logic                we_q, we_d;
  logic [ADDR_W+1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;

  logic [31:0] enc_word;
  logic        enc_illegal, enc_range_bad;
  logic        i_ok, b_ok, j_ok, u_ok;

  // Sign-extension checks: upper bits all equal means the value fits the field.
  assign i_ok = (&in_imm[31:11]) || ~(|in_imm[31:11]);
  assign b_ok = ((&in_imm[31:12]) || ~(|in_imm[31:12])) && !in_imm[0];
  assign j_ok = ((&in_imm[31:20]) || ~(|in_imm[31:20])) && !in_imm[0];
  assign u_ok = ~(|in_imm[11:0]);

  always_comb begin
    enc_word      = 32'h0;
    enc_illegal   = 1'b0;
    enc_range_bad = 1'b0;
    case (in_kind)
      4'd0:  enc_word = {7'b0000000, in_rs2, in_rs1, 3'b000, in_rd, OP_R};
      4'd1:  enc_word = {7'b0100000, in_rs2, in_rs1, 3'b000, in_rd, OP_R};
      4'd2:  enc_word = {7'b0000000, in_rs2, in_rs1, 3'b111, in_rd, OP_R};
      4'd3:  enc_word = {7'b0000000, in_rs2, in_rs1, 3'b110, in_rd, OP_R};
      4'd4:  enc_word = {7'b0000000, in_rs2, in_rs1, 3'b010, in_rd, OP_R};
      4'd5:  begin enc_word = {in_imm[11:0], in_rs1, 3'b000, in_rd, OP_IMM};  enc_range_bad = !i_ok; end
      4'd6:  begin enc_word = {in_imm[11:0], in_rs1, 3'b110, in_rd, OP_IMM};  enc_range_bad = !i_ok; end
      4'd7:  begin enc_word = {in_imm[11:0], in_rs1, 3'b010, in_rd, OP_IMM};  enc_range_bad = !i_ok; end
      4'd8:  begin enc_word = {in_imm[11:0], in_rs1, 3'b010, in_rd, OP_LD};   enc_range_bad = !i_ok; end
      4'd9:  begin
        enc_word = {in_imm[11:5], in_rs2, in_rs1, 3'b010, in_imm[4:0], OP_ST};
        enc_range_bad = !i_ok;
      end
      4'd10, 4'd11: begin
        enc_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, {2'b00, in_kind[0]},
                    in_imm[4:1], in_imm[11], OP_BR};
        enc_range_bad = !b_ok;
      end
      4'd12: begin
        enc_word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, OP_JAL};
        enc_range_bad = !j_ok;
      end
      4'd13: begin enc_word = {in_imm[11:0], in_rs1, 3'b000, in_rd, OP_JALR}; enc_range_bad = !i_ok; end
      4'd14: begin enc_word = {in_imm[31:12], in_rd, OP_LUI};                 enc_range_bad = !u_ok; end
      default: enc_illegal = 1'b1;
    endcase
  end

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    count_d = count_q;
    code_d  = code_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d = S_LOAD;
          word_d  = START_W;
          count_d = '0;
          code_d  = 2'd0;
        end
      end
      S_LOAD: begin
        if (in_valid) begin
          if (enc_illegal) begin
            state_d = S_ERR;
            code_d  = 2'd1;
          end else if (enc_range_bad) begin
            state_d = S_ERR;
            code_d  = 2'd2;
          end else begin
            we_d    = 1'b1;
            addr_d  = {word_q, 2'b00};
            wdata_d = enc_word;
            word_d  = word_q + ONE_W;
            count_d = count_q + ONE_C;
            // A final word exactly at the top of memory still counts as a clean finish.
            if (in_last) begin
              state_d = S_DONE;
            end else if (word_q == LAST_W) begin
              state_d = S_ERR;
              code_d  = 2'd3;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      word_q  <= '0;
      count_q <= '0;
      code_q  <= 2'd0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      count_q <= count_d;
      code_q  <= code_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign in_ready  = (state_q == S_LOAD);
  assign busy      = (state_q == S_LOAD);
  assign done      = (state_q == S_DONE);
  assign err       = (state_q == S_ERR);
  assign cpu_hold  = (state_q != S_DONE);
  assign err_code  = code_q;
  assign count     = count_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_riscv_instr_encoder.sv
// Bench for riscv_instr_encoder: directed program loads plus randomized sessions,
// checked against an arithmetic RV32I encoding model and a session model.
module tb_riscv_instr_encoder;
  localparam int ST_IDLE = 0, ST_LOAD = 1, ST_DONE = 2, ST_ERR = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, start_b, start_s, valid_b, valid_s, last, sel;
  logic [3:0]  kind;
  logic [4:0]  rd, rs1, rs2;
  logic [31:0] imm;

  logic        ready_b, we_b, busy_b, done_b, err_b, hold_b;
  logic [9:0]  addr_b;
  logic [31:0] wdata_b;
  logic [8:0]  count_b;
  logic [1:0]  code_b;

  logic        ready_s, we_s, busy_s, done_s, err_s, hold_s;
  logic [3:0]  addr_s;
  logic [31:0] wdata_s;
  logic [2:0]  count_s;
  logic [1:0]  code_s;

  riscv_instr_encoder #(.ADDR_W(8), .START_ADDR(0)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start_b), .in_valid(valid_b), .in_ready(ready_b),
    .in_kind(kind), .in_rd(rd), .in_rs1(rs1), .in_rs2(rs2), .in_imm(imm), .in_last(last),
    .mem_we(we_b), .mem_addr(addr_b), .mem_wdata(wdata_b), .count(count_b),
    .busy(busy_b), .done(done_b), .err(err_b), .err_code(code_b), .cpu_hold(hold_b));

  riscv_instr_encoder #(.ADDR_W(2), .START_ADDR(0)) u_small (
    .clk(clk), .rst_n(rst_n), .start(start_s), .in_valid(valid_s), .in_ready(ready_s),
    .in_kind(kind), .in_rd(rd), .in_rs1(rs1), .in_rs2(rs2), .in_imm(imm), .in_last(last),
    .mem_we(we_s), .mem_addr(addr_s), .mem_wdata(wdata_s), .count(count_s),
    .busy(busy_s), .done(done_s), .err(err_s), .err_code(code_s), .cpu_hold(hold_s));

  logic        t_ready, t_we, t_busy, t_done, t_err, t_hold;
  logic [9:0]  t_addr;
  logic [31:0] t_wdata;
  logic [8:0]  t_count;
  logic [1:0]  t_code;
  assign t_ready = sel ? ready_s : ready_b;
  assign t_we    = sel ? we_s    : we_b;
  assign t_busy  = sel ? busy_s  : busy_b;
  assign t_done  = sel ? done_s  : done_b;
  assign t_err   = sel ? err_s   : err_b;
  assign t_hold  = sel ? hold_s  : hold_b;
  assign t_addr  = sel ? {6'b0, addr_s}  : addr_b;
  assign t_wdata = sel ? wdata_s : wdata_b;
  assign t_count = sel ? {6'b0, count_s} : count_b;
  assign t_code  = sel ? code_s  : code_b;

  int checks = 0, failures = 0;
  int m_state, m_word, m_count, m_code, m_words;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference encoder: field placement by shifting, formats per the RV32I manual.
  function automatic void ref_encode(input int k, input int d, input int s1, input int s2,
                                     input int im, output logic [31:0] w, output int code);
    int unsigned ui, op, f3, f7;
    int fmt;
    ui = im; op = 0; f3 = 0; f7 = 0; fmt = 0; code = 0; w = 32'h0;
    case (k)
      0:  begin fmt = 0; op = 'h33; end
      1:  begin fmt = 0; op = 'h33; f7 = 'h20; end
      2:  begin fmt = 0; op = 'h33; f3 = 7; end
      3:  begin fmt = 0; op = 'h33; f3 = 6; end
      4:  begin fmt = 0; op = 'h33; f3 = 2; end
      5:  begin fmt = 1; op = 'h13; end
      6:  begin fmt = 1; op = 'h13; f3 = 6; end
      7:  begin fmt = 1; op = 'h13; f3 = 2; end
      8:  begin fmt = 1; op = 'h03; f3 = 2; end
      9:  begin fmt = 2; op = 'h23; f3 = 2; end
      10: begin fmt = 3; op = 'h63; end
      11: begin fmt = 3; op = 'h63; f3 = 1; end
      12: begin fmt = 4; op = 'h6F; end
      13: begin fmt = 1; op = 'h67; end
      14: begin fmt = 5; op = 'h37; end
      default: begin fmt = 9; code = 1; end
    endcase
    case (fmt)
      1, 2: if (im < -2048 || im > 2047) code = 2;
      3:    if (im < -4096 || im > 4094 || (im & 1) != 0) code = 2;
      4:    if (im < -1048576 || im > 1048574 || (im & 1) != 0) code = 2;
      5:    if ((ui & 'hFFF) != 0) code = 2;
      default: ;
    endcase
    case (fmt)
      0: w = (f7 << 25) | (s2 << 20) | (s1 << 15) | (f3 << 12) | (d << 7) | op;
      1: w = ((ui & 'hFFF) << 20) | (s1 << 15) | (f3 << 12) | (d << 7) | op;
      2: w = (((ui >> 5) & 'h7F) << 25) | (s2 << 20) | (s1 << 15) | (f3 << 12)
             | ((ui & 'h1F) << 7) | op;
      3: w = (((ui >> 12) & 1) << 31) | (((ui >> 5) & 'h3F) << 25) | (s2 << 20) | (s1 << 15)
             | (f3 << 12) | (((ui >> 1) & 'hF) << 8) | (((ui >> 11) & 1) << 7) | op;
      4: w = (((ui >> 20) & 1) << 31) | (((ui >> 1) & 'h3FF) << 21) | (((ui >> 11) & 1) << 20)
             | (((ui >> 12) & 'hFF) << 12) | (d << 7) | op;
      5: w = (ui & 'hFFFFF000) | (d << 7) | op;
      default: w = 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] gen_imm(input int k);
    int v;
    if ($urandom_range(0, 7) == 0) return $urandom();
    case (k)
      5, 6, 7, 8, 9, 13: v = int'($urandom_range(0, 4095)) - 2048;
      10, 11: v = (int'($urandom_range(0, 4095)) - 2048) * 2;
      12:     v = (int'($urandom_range(0, 1048575)) - 524288) * 2;
      14:     v = int'($urandom() & 32'hFFFFF000);
      default: v = int'($urandom());
    endcase
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_status();
    chk("busy", t_busy, m_state == ST_LOAD);
    chk("done", t_done, m_state == ST_DONE);
    chk("err", t_err, m_state == ST_ERR);
    chk("err_code", t_code, m_code);
    chk("cpu_hold", t_hold, m_state != ST_DONE);
    chk("count", t_count, m_count);
  endtask

  task automatic do_start();
    if (sel) start_s = 1'b1; else start_b = 1'b1;
    step();
    start_s = 1'b0; start_b = 1'b0;
    if (m_state != ST_LOAD) begin
      m_state = ST_LOAD; m_word = 0; m_count = 0; m_code = 0;
    end
    chk("start_we", t_we, 1'b0);
    chk_status();
  endtask

  task automatic send(input logic [3:0] k, input logic [4:0] d, input logic [4:0] s1,
                      input logic [4:0] s2, input logic [31:0] im, input logic lst);
    logic [31:0] w;
    int code;
    ref_encode(int'(k), int'(d), int'(s1), int'(s2), int'(im), w, code);
    kind = k; rd = d; rs1 = s1; rs2 = s2; imm = im; last = lst;
    if (sel) valid_s = 1'b1; else valid_b = 1'b1;
    chk("in_ready", t_ready, m_state == ST_LOAD);
    step();
    if (m_state == ST_LOAD && code != 0) begin
      m_state = ST_ERR; m_code = code;
      chk("we_on_error", t_we, 1'b0);
    end else if (m_state == ST_LOAD) begin
      chk("we", t_we, 1'b1);
      chk("addr", t_addr, m_word * 4);
      chk("wdata", t_wdata, w);
      m_count++;
      if (lst) m_state = ST_DONE;
      else if (m_word == m_words - 1) begin m_state = ST_ERR; m_code = 3; end
      m_word++;
    end else begin
      chk("we_not_loading", t_we, 1'b0);
    end
    chk_status();
  endtask

  task automatic idle();
    valid_b = 1'b0; valid_s = 1'b0;
    step();
    chk("we_idle", t_we, 1'b0);
    chk_status();
  endtask

  task automatic one_shot(input logic [3:0] k, input logic [31:0] im);
    do_start();
    send(k, 5'd1, 5'd2, 5'd3, im, 1'b1);
    idle();
  endtask

  initial begin
    rst_n = 1'b0; start_b = 1'b0; start_s = 1'b0; valid_b = 1'b0; valid_s = 1'b0;
    kind = 4'd0; rd = 5'd0; rs1 = 5'd0; rs2 = 5'd0; imm = 32'h0; last = 1'b0; sel = 1'b0;
    m_state = ST_IDLE; m_word = 0; m_count = 0; m_code = 0; m_words = 256;
    repeat (3) step();
    chk("rst_we", t_we, 1'b0);
    chk("rst_addr", t_addr, 10'h0);
    chk("rst_wdata", t_wdata, 32'h0);
    chk("rst_ready", t_ready, 1'b0);
    chk_status();
    rst_n = 1'b1;
    step();

    // add / sub / lui program
    do_start();
    send(4'd0, 5'd3, 5'd1, 5'd2, 32'h0, 1'b0);          chk("tp_add", t_wdata, 32'h002081B3);
    send(4'd1, 5'd5, 5'd6, 5'd7, 32'h0, 1'b0);          chk("tp_sub", t_wdata, 32'h407302B3);
    send(4'd14, 5'd1, 5'd0, 5'd0, 32'h12345000, 1'b1);  chk("tp_lui", t_wdata, 32'h123450B7);
    idle();

    // back-to-back addi / sw / beq
    do_start();
    send(4'd5, 5'd1, 5'd0, 5'd0, 32'hFFFFFFFF, 1'b0);   chk("tp_addi", t_wdata, 32'hFFF00093);
    send(4'd9, 5'd0, 5'd1, 5'd2, 32'd8, 1'b0);          chk("tp_sw", t_wdata, 32'h0020A423);
    send(4'd10, 5'd0, 5'd1, 5'd2, 32'hFFFFFFF8, 1'b1);  chk("tp_beq", t_wdata, 32'hFE208CE3);
    idle();

    // jal / jalr, with a start pulse mid-session that must be ignored
    do_start();
    send(4'd12, 5'd1, 5'd0, 5'd0, 32'd2048, 1'b0);      chk("tp_jal", t_wdata, 32'h001000EF);
    start_b = 1'b1;
    send(4'd13, 5'd0, 5'd1, 5'd0, 32'd0, 1'b1);         chk("tp_jalr", t_wdata, 32'h00008067);
    start_b = 1'b0;
    idle();

    // immediate boundaries and illegal kind
    one_shot(4'd5, 32'd2048);          chk("tp_addi_range_code", t_code, 2'd2);
    one_shot(4'd5, 32'd2047);
    one_shot(4'd7, 32'hFFFFF800);
    one_shot(4'd9, 32'hFFFFF7FF);
    one_shot(4'd10, 32'd4094);
    one_shot(4'd11, 32'd4095);
    one_shot(4'd10, 32'hFFFFF000);
    one_shot(4'd10, 32'd4096);
    one_shot(4'd12, 32'hFFF00000);
    one_shot(4'd12, 32'd1048576);
    one_shot(4'd12, 32'd3);
    one_shot(4'd14, 32'h00001001);
    one_shot(4'd15, 32'd0);            chk("tp_illegal_code", t_code, 2'd1);

    // overflow on the 4-word instance, then restart
    sel = 1'b1; m_words = 4;
    do_start();
    for (int i = 0; i < 4; i++) send(4'd2, 5'(i), 5'd1, 5'd2, 32'h0, 1'b0);
    chk("tp_ovf_code", t_code, 2'd3);
    idle();
    do_start();
    send(4'd3, 5'd9, 5'd8, 5'd7, 32'h0, 1'b1);
    idle();
    // last word exactly at the top of memory finishes cleanly
    do_start();
    for (int i = 0; i < 4; i++) send(4'd4, 5'd4, 5'd5, 5'd6, 32'h0, i == 3);
    idle();
    sel = 1'b0; m_words = 256;

    // randomized sessions
    for (int s = 0; s < 6; s++) begin
      int n;
      do_start();
      n = $urandom_range(3, 12);
      for (int i = 0; i < n; i++) begin
        logic [3:0] k;
        k = ($urandom_range(0, 19) == 0) ? 4'd15 : 4'($urandom_range(0, 14));
        send(k, 5'($urandom()), 5'($urandom()), 5'($urandom()), gen_imm(int'(k)), i == n - 1);
        if (m_state != ST_LOAD) break;
      end
      idle();
    end

    // asynchronous reset in the middle of a back-to-back stream
    do_start();
    send(4'd0, 5'd1, 5'd2, 5'd3, 32'h0, 1'b0);
    send(4'd1, 5'd4, 5'd5, 5'd6, 32'h0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    m_state = ST_IDLE; m_word = 0; m_count = 0; m_code = 0;
    chk("arst_we", t_we, 1'b0);
    chk("arst_addr", t_addr, 10'h0);
    chk("arst_ready", t_ready, 1'b0);
    chk_status();
    valid_b = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    chk("post_rst_we", t_we, 1'b0);
    chk_status();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
